// File: rtl/cbus_err_capture.sv
// rtl/cbus_err_capture.sv - cbus timeout error capture: shadow, rise detect, capture FSM, saturating count, irq
// Optional: CBUS_ERR_TIMESTAMP_EN adds a free-running timestamp captured alongside the address.
module cbus_err_capture #(
  parameter int AW  = 16,
  parameter int DW  = 32,
  parameter int CW  = 8,
  parameter int TSW = 16
) (
  input  logic          clk,
  input  logic          sreset,
  input  logic          cbus_m_req,
  input  logic          cbus_m_cmd,
  input  logic [AW-1:0] cbus_m_addr,
  input  logic [DW-1:0] cbus_m_wdata,
  input  logic          cbus_access_err,
  input  logic          err_clr,
  input  logic          cnt_clr,
  input  logic          irq_en,
  output logic          err_valid,
  output logic [AW-1:0] err_addr,
  output logic          err_cmd,
  output logic [DW-1:0] err_wdata,
  output logic          err_overflow,
  output logic [CW-1:0] err_cnt,
  output logic          err_irq
`ifdef CBUS_ERR_TIMESTAMP_EN
  ,
  output logic [TSW-1:0] err_ts
`endif
);

  typedef enum logic {IDLE, HELD} state_t;

  state_t        r_state;
  logic [AW-1:0] r_sh_addr;
  logic          r_sh_cmd;
  logic [DW-1:0] r_sh_wdata;
  logic          r_err_d;
  logic          r_valid;
  logic [AW-1:0] r_addr;
  logic          r_cmd;
  logic [DW-1:0] r_wdata;
  logic          r_ovf;
  logic [CW-1:0] r_cnt;
  logic          r_irq;
  logic          w_rise;

  assign w_rise = cbus_access_err & ~r_err_d;

  // The error level lags the timed-out request, so the request is shadowed and held.
  always_ff @(posedge clk) begin
    if (sreset) begin
      r_sh_addr  <= '0;
      r_sh_cmd   <= 1'b0;
      r_sh_wdata <= '0;
      r_err_d    <= 1'b0;
    end else begin
      r_err_d <= cbus_access_err;
      if (cbus_m_req) begin
        r_sh_addr  <= cbus_m_addr;
        r_sh_cmd   <= cbus_m_cmd;
        r_sh_wdata <= cbus_m_cmd ? '0 : cbus_m_wdata;
      end
    end
  end

`ifdef CBUS_ERR_TIMESTAMP_EN
  logic [TSW-1:0] r_ts;
  logic [TSW-1:0] r_err_ts;
  assign err_ts = r_err_ts;
`endif

  always_ff @(posedge clk) begin
    if (sreset) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_cmd   <= 1'b0;
      r_wdata <= '0;
      r_ovf   <= 1'b0;
`ifdef CBUS_ERR_TIMESTAMP_EN
      r_ts     <= '0;
      r_err_ts <= '0;
`endif
    end else begin
`ifdef CBUS_ERR_TIMESTAMP_EN
      r_ts <= r_ts + 1'b1;
`endif
      case (r_state)
        IDLE: begin
          if (w_rise) begin
            r_addr  <= r_sh_addr;
            r_cmd   <= r_sh_cmd;
            r_wdata <= r_sh_wdata;
            r_valid <= 1'b1;
            r_state <= HELD;
`ifdef CBUS_ERR_TIMESTAMP_EN
            r_err_ts <= r_ts;
`endif
          end
        end
        HELD: begin
          if (w_rise && err_clr) begin
            r_addr  <= r_sh_addr;
            r_cmd   <= r_sh_cmd;
            r_wdata <= r_sh_wdata;
            r_ovf   <= 1'b0;
`ifdef CBUS_ERR_TIMESTAMP_EN
            r_err_ts <= r_ts;
`endif
          end else if (w_rise) begin
            r_ovf <= 1'b1;
          end else if (err_clr) begin
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Clear wins over saturation; a coincident rise still counts as the first event.
  always_ff @(posedge clk) begin
    if (sreset) begin
      r_cnt <= '0;
      r_irq <= 1'b0;
    end else begin
      r_irq <= r_valid & irq_en;
      if (cnt_clr) begin
        r_cnt <= w_rise ? CW'(1) : '0;
      end else if (w_rise && (r_cnt != {CW{1'b1}})) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign err_valid    = r_valid;
  assign err_addr     = r_addr;
  assign err_cmd      = r_cmd;
  assign err_wdata    = r_wdata;
  assign err_overflow = r_ovf;
  assign err_cnt      = r_cnt;
  assign err_irq      = r_irq;

endmodule

// File: tb/tb_cbus_err_capture.sv
// tb/tb_cbus_err_capture.sv - scoreboard bench for cbus_err_capture (CBUS_ERR_TIMESTAMP_EN adds ts case)
module tb_cbus_err_capture;
  localparam int AW = 16, DW = 32, CW = 8, TSW = 16;

  logic          clk = 1'b0;
  logic          sreset = 1'b1;
  logic          cbus_m_req = 1'b0;
  logic          cbus_m_cmd = 1'b0;
  logic [AW-1:0] cbus_m_addr = '0;
  logic [DW-1:0] cbus_m_wdata = '0;
  logic          cbus_access_err = 1'b0;
  logic          err_clr = 1'b0;
  logic          cnt_clr = 1'b0;
  logic          irq_en = 1'b0;
  logic          err_valid;
  logic [AW-1:0] err_addr;
  logic          err_cmd;
  logic [DW-1:0] err_wdata;
  logic          err_overflow;
  logic [CW-1:0] err_cnt;
  logic          err_irq;
`ifdef CBUS_ERR_TIMESTAMP_EN
  logic [TSW-1:0] err_ts;
`endif

  cbus_err_capture #(.AW(AW), .DW(DW), .CW(CW), .TSW(TSW)) dut (
    .clk(clk), .sreset(sreset),
    .cbus_m_req(cbus_m_req), .cbus_m_cmd(cbus_m_cmd),
    .cbus_m_addr(cbus_m_addr), .cbus_m_wdata(cbus_m_wdata),
    .cbus_access_err(cbus_access_err), .err_clr(err_clr), .cnt_clr(cnt_clr),
    .irq_en(irq_en), .err_valid(err_valid), .err_addr(err_addr),
    .err_cmd(err_cmd), .err_wdata(err_wdata), .err_overflow(err_overflow),
    .err_cnt(err_cnt), .err_irq(err_irq)
`ifdef CBUS_ERR_TIMESTAMP_EN
    , .err_ts(err_ts)
`endif
  );

  always #5 clk = ~clk;

  typedef enum int {S_VALID, S_ADDR, S_CMD, S_WDATA, S_OVF, S_CNT, S_IRQ, S_TS} sel_t;
  typedef struct {
    string       name;
    sel_t        sel;
    logic [63:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic logic [63:0] dut_val(sel_t s);
    case (s)
      S_VALID: return 64'(err_valid);
      S_ADDR:  return 64'(err_addr);
      S_CMD:   return 64'(err_cmd);
      S_WDATA: return 64'(err_wdata);
      S_OVF:   return 64'(err_overflow);
      S_CNT:   return 64'(err_cnt);
      S_IRQ:   return 64'(err_irq);
`ifdef CBUS_ERR_TIMESTAMP_EN
      S_TS:    return 64'(err_ts);
`endif
      default: return 64'hX;
    endcase
  endfunction

  // Monitor: drains expectations against the outputs settled after the last posedge.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      logic [63:0] act;
      e = sb.pop_front();
      act = dut_val(e.sel);
      n_checks++;
      if (act !== e.exp) begin
        n_errors++;
        $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.exp);
      end
    end
  end

  task automatic expect_v(string name, sel_t sel, logic [63:0] v);
    exp_t e;
    e.name = name; e.sel = sel; e.exp = v;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(logic cmd, logic [AW-1:0] a, logic [DW-1:0] d);
    cbus_m_req = 1'b1; cbus_m_cmd = cmd; cbus_m_addr = a; cbus_m_wdata = d;
    tick();
    cbus_m_req = 1'b0; cbus_m_cmd = ~cmd; cbus_m_addr = '1; cbus_m_wdata = 32'h5555_5555;
    tick();
    tick();
  endtask

  task automatic pulse(int len);
    cbus_access_err = 1'b1;
    repeat (len) tick();
    cbus_access_err = 1'b0;
    repeat (2) tick();
  endtask

  task automatic expect_all_zero(string tag);
    expect_v({tag, "_valid"}, S_VALID, 0);
    expect_v({tag, "_addr"},  S_ADDR,  0);
    expect_v({tag, "_cmd"},   S_CMD,   0);
    expect_v({tag, "_wdata"}, S_WDATA, 0);
    expect_v({tag, "_ovf"},   S_OVF,   0);
    expect_v({tag, "_cnt"},   S_CNT,   0);
    expect_v({tag, "_irq"},   S_IRQ,   0);
  endtask

  initial begin
    repeat (3) tick();
    expect_all_zero("reset");
    sreset = 1'b0;
    irq_en = 1'b1;
    tick();

    // Write timeout, 32-clock stretched error
    do_req(1'b0, 16'h1234, 32'hDEAD_BEEF);
    cbus_access_err = 1'b1;
    tick();
    expect_v("t1_valid", S_VALID, 1);
    expect_v("t1_addr",  S_ADDR,  64'h1234);
    expect_v("t1_cmd",   S_CMD,   0);
    expect_v("t1_wdata", S_WDATA, 64'hDEAD_BEEF);
    expect_v("t1_cnt",   S_CNT,   1);
    expect_v("t1_irq_lag", S_IRQ, 0);
    tick();
    expect_v("t1_irq", S_IRQ, 1);
    repeat (30) tick();
    cbus_access_err = 1'b0;
    repeat (2) tick();
    expect_v("t1_cnt_once", S_CNT, 1);
    irq_en = 1'b0;
    tick();
    expect_v("irq_en_off_irq", S_IRQ, 0);
    expect_v("irq_en_off_valid", S_VALID, 1);
    irq_en = 1'b1;
    tick();
    expect_v("irq_en_on_irq", S_IRQ, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    expect_v("clr_valid", S_VALID, 0);
    expect_v("clr_addr_kept", S_ADDR, 64'h1234);
    expect_v("clr_cnt_kept", S_CNT, 1);
    tick();
    expect_v("clr_irq", S_IRQ, 0);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    expect_v("cnt_clr0", S_CNT, 0);

    // Read timeout, then second error while held
    do_req(1'b1, 16'h0040, 32'h1111_1111);
    pulse(32);
    expect_v("t2_addr",  S_ADDR,  64'h0040);
    expect_v("t2_cmd",   S_CMD,   1);
    expect_v("t2_wdata", S_WDATA, 0);
    expect_v("t2_ovf0",  S_OVF,   0);
    do_req(1'b0, 16'h0080, 32'hAAAA_AAAA);
    pulse(32);
    expect_v("t2_addr_held", S_ADDR, 64'h0040);
    expect_v("t2_cmd_held",  S_CMD,  1);
    expect_v("t2_wdata_held", S_WDATA, 0);
    expect_v("t2_ovf", S_OVF, 1);
    expect_v("t2_cnt", S_CNT, 2);

    // err_clr coincident with rise recaptures
    do_req(1'b0, 16'h0100, 32'hCAFE_F00D);
    cbus_access_err = 1'b1;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    expect_v("t3_valid", S_VALID, 1);
    expect_v("t3_addr",  S_ADDR,  64'h0100);
    expect_v("t3_wdata", S_WDATA, 64'hCAFE_F00D);
    expect_v("t3_ovf",   S_OVF,   0);
    expect_v("t3_cnt",   S_CNT,   3);
    repeat (31) tick();
    cbus_access_err = 1'b0;
    repeat (2) tick();

    // Saturation
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    for (int i = 0; i < 255; i++) begin
      cbus_access_err = 1'b1; tick();
      cbus_access_err = 1'b0; tick();
    end
    expect_v("t4_cnt_255", S_CNT, 255);
    for (int i = 0; i < 5; i++) begin
      cbus_access_err = 1'b1; tick();
      cbus_access_err = 1'b0; tick();
    end
    expect_v("t4_cnt_sat", S_CNT, 255);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    expect_v("t4_cnt_clr", S_CNT, 0);
    cbus_access_err = 1'b1;
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    cbus_access_err = 1'b0;
    expect_v("t4_cnt_clr_rise", S_CNT, 1);
    tick();

    // Extended pulse counted once; reset in HELD
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    expect_v("t5_idle", S_VALID, 0);
    pulse(64);
    expect_v("t5_cnt", S_CNT, 2);
    expect_v("t5_valid", S_VALID, 1);
    sreset = 1'b1;
    tick();
    sreset = 1'b0;
    expect_all_zero("t5_rst");
    tick();

`ifdef CBUS_ERR_TIMESTAMP_EN
    sreset = 1'b1;
    tick();
    sreset = 1'b0;
    expect_v("t6_ts_rst", S_TS, 0);
    repeat (100) tick();
    cbus_access_err = 1'b1;
    tick();
    cbus_access_err = 1'b0;
    expect_v("t6_ts", S_TS, 100);
    repeat (20) tick();
    expect_v("t6_ts_hold", S_TS, 100);
`endif

    repeat (3) tick();
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
